// File: rtl/adder_pkg.sv
// Shared definitions for the multi-byte add sequencer and its neighbours.
//   BYTE_W      : width of one adder slice (8 bits)
//   seq_state_t : sequencer control states
//   idx_width() : bit width of the byte-index counter for a given byte count
package adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // max(1, clog2(num_bytes)): a single-byte operand still needs a 1-bit index.
  function automatic int idx_width(input int num_bytes);
    return (num_bytes <= 2) ? 1 : $clog2(num_bytes);
  endfunction

endpackage

// File: rtl/multibyte_add_sequencer.sv
// Multi-byte adder sequencer: walks a wide addition through an external
// 8-bit adder one byte per cycle, least-significant byte first.
//
// Ports:
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   : request handshake; in_a, in_b, in_cin are operands
//   add_a, add_b, add_cin : drive the external 8-bit adder (zero outside RUN)
//   add_sum, add_cout     : combinational result of that adder, same cycle
//   out_valid / out_ready : result handshake
//   out_sum, out_cout     : assembled sum and carry out of the top byte
//   out_ovf               : two's-complement overflow of the full-width add
//   busy                  : high while an operation is running or waiting to retire
module multibyte_add_sequencer
  import adder_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BYTE_W*NUM_BYTES-1:0] in_a,
  input  logic [BYTE_W*NUM_BYTES-1:0] in_b,
  input  logic                        in_cin,
  output logic [BYTE_W-1:0]           add_a,
  output logic [BYTE_W-1:0]           add_b,
  output logic                        add_cin,
  input  logic [BYTE_W-1:0]           add_sum,
  input  logic                        add_cout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W*NUM_BYTES-1:0] out_sum,
  output logic                        out_cout,
  output logic                        out_ovf,
  output logic                        busy
);

  localparam int W        = BYTE_W * NUM_BYTES;
  localparam int IW       = idx_width(NUM_BYTES);
  localparam int NSLOT    = 1 << IW;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  seq_state_t state_reg, state_next;

  logic [W-1:0]  a_reg, b_reg, result_reg, result_next;
  logic          cin_reg, carry_reg;
  logic [IW-1:0] idx_reg;
  logic          accept;

  // Byte views of the operands, padded to a power-of-two count so the
  // index counter addresses every slot without a range mismatch.
  logic [BYTE_W-1:0] a_bytes [NSLOT];
  logic [BYTE_W-1:0] b_bytes [NSLOT];

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NUM_BYTES) begin : g_real
        assign a_bytes[gi] = a_reg[gi*BYTE_W +: BYTE_W];
        assign b_bytes[gi] = b_reg[gi*BYTE_W +: BYTE_W];
      end else begin : g_pad
        assign a_bytes[gi] = '0;
        assign b_bytes[gi] = '0;
      end
    end
  endgenerate

  // Only the byte currently being added takes the adder's sum.
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_res
      assign result_next[gi*BYTE_W +: BYTE_W] =
        (state_reg == RUN && idx_reg == IW'(gi)) ? add_sum
                                                 : result_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  assign accept = in_valid && (state_reg == IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake / adder-drive outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_bytes[idx_reg];
        add_b   = b_bytes[idx_reg];
        add_cin = (idx_reg == '0) ? cin_reg : carry_reg;
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and byte-serial datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      cin_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      idx_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg      <= in_a;
            b_reg      <= in_b;
            cin_reg    <= in_cin;
            carry_reg  <= 1'b0;
            result_reg <= '0;
            idx_reg    <= '0;
          end
        end
        RUN: begin
          result_reg <= result_next;
          carry_reg  <= add_cout;
          // The last byte leaves the index parked; the FSM exits RUN instead.
          if (idx_reg != LAST_IDX) idx_reg <= idx_reg + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result outputs are meaningful only while out_valid is high.
  assign out_sum  = out_valid ? result_reg : '0;
  assign out_cout = out_valid && carry_reg;
  assign out_ovf  = out_valid && (a_reg[W-1] == b_reg[W-1]) &&
                    (result_reg[W-1] != a_reg[W-1]);

endmodule

// File: doc/multibyte_add_sequencer.md
# multibyte_add_sequencer

Sequences wide (multi-byte) addition through the single 8-bit adder stage, one byte per cycle, least-significant byte first. It registers the inter-byte carry, assembles the full-width result and reports carry-out and signed overflow. It sits directly upstream of the 8-bit adder, driving its a/b/cin inputs, and consumes that stage's sum/cout outputs in the same cycle. It exposes valid/ready handshakes toward its producer and consumer.

## Interface
- `NUM_BYTES`, default 4: operand width in bytes. Legal range is 1..16.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand request valid.
- `in_ready` output 1: block can accept a request.
- `in_a` input 8*NUM_BYTES: operand A.
- `in_b` input 8*NUM_BYTES: operand B.
- `in_cin` input 1: carry into byte 0.
- `add_a` output 8: byte to the adder's a input.
- `add_b` output 8: byte to the adder's b input.
- `add_cin` output 1: carry to the adder's cin input.
- `add_sum` input 8: adder sum. Combinational, same cycle.
- `add_cout` input 1: adder carry-out. Combinational, same cycle.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_sum` output 8*NUM_BYTES: assembled sum.
- `out_cout` output 1: carry out of the MSB byte.
- `out_ovf` output 1: two's-complement overflow.
- `busy` output 1: high in RUN or DONE.

## Operation
- States:
  - IDLE → RUN on `in_valid && in_ready`.
  - RUN → DONE when byte index == NUM_BYTES-1.
  - DONE → IDLE on `out_valid && out_ready`.
- `in_ready` = (state == IDLE). `in_valid` in any other state is ignored; no queuing.
- Accept: capture `in_a`, `in_b` and `in_cin` into registers; clear the byte index and the result register.
- RUN, index k:
  - `add_a` = a_reg[8k+7:8k] and `add_b` = b_reg[8k+7:8k].
  - `add_cin` = cin_reg when k == 0, else carry_reg.
  - On the clock edge: result[8k+7:8k] ← `add_sum`, carry_reg ← `add_cout`, k ← k+1.
- The index counter is max(1, clog2(NUM_BYTES)) bits. It never wraps; the last byte forces the RUN → DONE transition.
- Outputs in DONE:
  - `out_sum` = result.
  - `out_cout` = carry_reg.
  - `out_ovf` = (a_reg MSB == b_reg MSB) && (result MSB != a_reg MSB).
- `out_valid` = (state == DONE). `out_sum`, `out_cout` and `out_ovf` are held stable until the handshake completes.
- Outside RUN, `add_a`, `add_b` and `add_cin` are driven to 0.
- Reset values:
  - State is IDLE.
  - All registers are 0.
  - `in_ready` = 1.
  - `out_valid`, `busy`, `out_cout`, `out_ovf` = 0.
  - `out_sum` = 0.
- Reset mid-operation aborts the transaction. The partial result is discarded and no `out_valid` is emitted. The upstream producer must re-issue the request.

## Timing
- Request accepted at edge 0. Byte k is presented in cycle k+1. `out_valid` rises after edge NUM_BYTES, i.e. latency NUM_BYTES+1 cycles from acceptance.
- Output handshake at edge t returns the block to IDLE, so `in_ready` = 1 in cycle t+1. There is no same-cycle output-retire plus input-accept.
- Throughput is one operation per NUM_BYTES+2 cycles when `out_ready` is held at 1.
- The adder path (`add_*` outputs → adder → `add_sum`/`add_cout` → registers) is one combinational cycle. There is no register between this block and the adder.
- NUM_BYTES = 1: RUN lasts exactly one cycle, and `add_cin` = cin_reg.

## Structure
- Shared package `adder_pkg`:
  - `BYTE_W` = 8.
  - State enum `seq_state_t` {IDLE, RUN, DONE}.
  - Function computing the index width from NUM_BYTES.
- No sub-module inside this block. The 8-bit adder is a sibling instance wired at the parent level.

## Test plan
All cases use NUM_BYTES=4.
- Carry ripple: a=0x000000FF, b=0x00000001, cin=0 → sum=0x00000100, cout=0, ovf=0. `out_valid` asserts 5 cycles after accept, and `add_cin`=1 is seen in byte 1.
- Full carry out: a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000 → sum=0, cout=1, ovf=1.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → outputs stable and `in_ready`=0 throughout. `in_valid` pulses with other operands are ignored. After `out_ready`=1, `in_ready`=1 the next cycle.
- Reset mid-RUN: assert `rst` during byte 2 of a=0x12345678, b=0x11111111 → `out_valid`=0 and `in_ready`=1 immediately. A new request 0x1+0x1 then yields sum=0x00000002.
- Back-to-back: three requests with `out_ready` tied high → each completes in 6 cycles, and results match the reference sum modulo 2^32.
